// File: rtl/alu_checker.sv
// Response checker for the ALU top: golden model, latency-matched compare,
// saturating pass/fail counters and first-mismatch capture.
module alu_checker #(
   parameter int LATENCY = 1,
   parameter int IW      = 4,
   parameter int OW      = 8,
   parameter int CW      = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [IW-1:0] a,
   input  logic [IW-1:0] b,
   input  logic [1:0]    op,
   input  logic [OW-1:0] out,
   input  logic          clr,
   output logic          cmp_vld,
   output logic          err,
   output logic          fail,
   output logic [CW-1:0] pass_cnt,
   output logic [CW-1:0] fail_cnt,
   output logic [1:0]    ff_op,
   output logic [OW-1:0] ff_exp,
   output logic [OW-1:0] ff_got
);

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      CHECK,
      FAIL_LATCH
   } state_t;

   state_t state;
   logic [2:0] idle_cnt;

   logic signed [OW-1:0] ax;
   logic signed [OW-1:0] bx;
   logic [IW-1:0]        ab;
   logic [OW-1:0]        gold;

   logic [LATENCY-1:0] vld_q;
   logic [1:0]         op_q  [LATENCY];
   logic [OW-1:0]      exp_q [LATENCY];

   logic          hd_vld;
   logic [1:0]    hd_op;
   logic [OW-1:0] hd_exp;
   logic          mis;
   logic          any_vld;

   always_comb begin
      ax   = {{(OW-IW){a[IW-1]}}, a};
      bx   = {{(OW-IW){b[IW-1]}}, b};
      ab   = a & b;
      gold = '0;
      unique case (op)
         2'b00:   gold = ax + bx;
         2'b01:   gold = ax - bx;
         2'b10:   gold = ax * bx;
         default: gold = {{(OW-IW){ab[IW-1]}}, ab};
      endcase
   end

   assign hd_vld  = vld_q[LATENCY-1];
   assign hd_op   = op_q[LATENCY-1];
   assign hd_exp  = exp_q[LATENCY-1];
   assign mis     = hd_vld && (hd_exp != out);
   assign any_vld = |vld_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q    <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            op_q[i]  <= '0;
            exp_q[i] <= '0;
         end
         cmp_vld  <= 1'b0;
         err      <= 1'b0;
         fail     <= 1'b0;
         pass_cnt <= '0;
         fail_cnt <= '0;
         ff_op    <= '0;
         ff_exp   <= '0;
         ff_got   <= '0;
         state    <= IDLE;
         idle_cnt <= '0;
      end else begin
         vld_q[0] <= en;
         op_q[0]  <= op;
         exp_q[0] <= gold;
         for (int i = 1; i < LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
            op_q[i]  <= op_q[i-1];
            exp_q[i] <= exp_q[i-1];
         end

         cmp_vld <= hd_vld;
         err     <= mis;

         if (clr) begin
            fail     <= 1'b0;
            pass_cnt <= '0;
            fail_cnt <= '0;
            ff_op    <= '0;
            ff_exp   <= '0;
            ff_got   <= '0;
         end

         // a compare in the clear cycle is the first post-clear result
         if (hd_vld) begin
            if (mis) begin
               if (clr)
                  fail_cnt <= CW'(1);
               else if (fail_cnt != '1)
                  fail_cnt <= fail_cnt + 1'b1;
               fail <= 1'b1;
               if (clr || !fail) begin
                  ff_op  <= hd_op;
                  ff_exp <= hd_exp;
                  ff_got <= out;
               end
            end else begin
               if (clr)
                  pass_cnt <= CW'(1);
               else if (pass_cnt != '1)
                  pass_cnt <= pass_cnt + 1'b1;
            end
         end

         unique case (state)
            IDLE: begin
               idle_cnt <= '0;
               if (en || any_vld)
                  state <= FILL;
            end
            FILL: begin
               idle_cnt <= '0;
               if (hd_vld)
                  state <= CHECK;
            end
            CHECK: begin
               if (any_vld) begin
                  idle_cnt <= '0;
               end else if (idle_cnt == 3'(LATENCY - 1)) begin
                  idle_cnt <= '0;
                  state    <= IDLE;
               end else begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
            end
            FAIL_LATCH: begin
               idle_cnt <= '0;
               state    <= CHECK;
            end
         endcase
         if (mis)
            state <= FAIL_LATCH;
      end
   end

endmodule

// File: tb/tb_alu_checker.sv
// Scoreboard bench for alu_checker: a LATENCY=1/CW=8 and a LATENCY=2/CW=2
// instance share stimulus; each sees its own delayed ALU result.
module tb_alu_checker;

   typedef struct {
      logic       vld;
      logic       bad;
      logic [1:0] op;
      logic [7:0] exp;
      logic [7:0] got;
   } ent_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b0;
   logic       clr = 1'b0;
   logic [3:0] a   = '0;
   logic [3:0] b   = '0;
   logic [1:0] op  = '0;
   logic [7:0] out1 = '0;
   logic [7:0] out2 = '0;
   logic [7:0] d1   = '0;

   logic       d_cmp, d_err, d_fail;
   logic [7:0] d_pc, d_fc;
   logic [1:0] d_fo;
   logic [7:0] d_fe, d_fg;

   logic       s_cmp, s_err, s_fail;
   logic [1:0] s_pc, s_fc;
   logic [1:0] s_fo;
   logic [7:0] s_fe, s_fg;

   int n_chk  = 0;
   int n_fail = 0;

   ent_t q0[$];
   ent_t q1[$];

   int         m_pc [2];
   int         m_fc [2];
   logic       m_fl [2];
   logic [1:0] m_fo [2];
   logic [7:0] m_fe [2];
   logic [7:0] m_fg [2];

   always #5 clk = ~clk;

   alu_checker #(.LATENCY(1), .IW(4), .OW(8), .CW(8)) u_dut (
      .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .op(op),
      .out(out1), .clr(clr),
      .cmp_vld(d_cmp), .err(d_err), .fail(d_fail),
      .pass_cnt(d_pc), .fail_cnt(d_fc),
      .ff_op(d_fo), .ff_exp(d_fe), .ff_got(d_fg)
   );

   alu_checker #(.LATENCY(2), .IW(4), .OW(8), .CW(2)) u_sat (
      .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .op(op),
      .out(out2), .clr(clr),
      .cmp_vld(s_cmp), .err(s_err), .fail(s_fail),
      .pass_cnt(s_pc), .fail_cnt(s_fc),
      .ff_op(s_fo), .ff_exp(s_fe), .ff_got(s_fg)
   );

   task automatic chk_eq(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] golden(input logic [3:0] ia,
                                         input logic [3:0] ib,
                                         input logic [1:0] iop);
      int sa, sb, r;
      logic [3:0] t;
      sa = $signed(ia);
      sb = $signed(ib);
      t  = ia & ib;
      case (iop)
         2'd0:    r = sa + sb;
         2'd1:    r = sa - sb;
         2'd2:    r = sa * sb;
         default: r = $signed(t);
      endcase
      return 8'(r);
   endfunction

   task automatic model(input int k, input ent_t e, input logic c);
      int mx;
      mx = (k == 0) ? 255 : 3;
      if (c) begin
         m_pc[k] = 0; m_fc[k] = 0; m_fl[k] = 1'b0;
         m_fo[k] = '0; m_fe[k] = '0; m_fg[k] = '0;
      end
      if (e.vld) begin
         if (e.bad) begin
            if (m_fc[k] < mx) m_fc[k]++;
            if (!m_fl[k]) begin
               m_fo[k] = e.op; m_fe[k] = e.exp; m_fg[k] = e.got;
            end
            m_fl[k] = 1'b1;
         end else if (m_pc[k] < mx) begin
            m_pc[k]++;
         end
      end
   endtask

   task automatic check_all(input logic c);
      ent_t e0, e1;
      e0 = '{vld: 1'b0, bad: 1'b0, op: 2'b0, exp: 8'h0, got: 8'h0};
      e1 = e0;
      if (q0.size() > 1) e0 = q0.pop_front();
      if (q1.size() > 2) e1 = q1.pop_front();
      model(0, e0, c);
      model(1, e1, c);
      chk_eq("d_cmp_vld", 8'(d_cmp), 8'(e0.vld));
      chk_eq("d_err", 8'(d_err), 8'(e0.vld & e0.bad));
      chk_eq("d_fail", 8'(d_fail), 8'(m_fl[0]));
      chk_eq("d_pass_cnt", d_pc, 8'(m_pc[0]));
      chk_eq("d_fail_cnt", d_fc, 8'(m_fc[0]));
      chk_eq("d_ff_op", 8'(d_fo), 8'(m_fo[0]));
      chk_eq("d_ff_exp", d_fe, m_fe[0]);
      chk_eq("d_ff_got", d_fg, m_fg[0]);
      chk_eq("s_cmp_vld", 8'(s_cmp), 8'(e1.vld));
      chk_eq("s_err", 8'(s_err), 8'(e1.vld & e1.bad));
      chk_eq("s_fail", 8'(s_fail), 8'(m_fl[1]));
      chk_eq("s_pass_cnt", 8'(s_pc), 8'(m_pc[1]));
      chk_eq("s_fail_cnt", 8'(s_fc), 8'(m_fc[1]));
      chk_eq("s_ff_op", 8'(s_fo), 8'(m_fo[1]));
      chk_eq("s_ff_exp", s_fe, m_fe[1]);
      chk_eq("s_ff_got", s_fg, m_fg[1]);
   endtask

   task automatic step(input logic e, input logic [3:0] ia,
                       input logic [3:0] ib, input logic [1:0] iop,
                       input logic [7:0] flip, input logic c);
      ent_t n;
      en = e; a = ia; b = ib; op = iop; clr = c;
      n.vld = e;
      n.op  = iop;
      n.exp = golden(ia, ib, iop);
      n.got = e ? (n.exp ^ flip) : 8'($urandom);
      n.bad = e && (flip != 8'h0);
      q0.push_back(n);
      q1.push_back(n);
      @(posedge clk);
      #1;
      out2 = d1;
      d1   = n.got;
      out1 = n.got;
      check_all(c);
   endtask

   task automatic idle();
      step(1'b0, 4'h0, 4'h0, 2'b00, 8'h00, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b0; clr = 1'b0;
      out1 = '0; out2 = '0; d1 = '0;
      q0.delete();
      q1.delete();
      for (int k = 0; k < 2; k++) begin
         m_pc[k] = 0; m_fc[k] = 0; m_fl[k] = 1'b0;
         m_fo[k] = '0; m_fe[k] = '0; m_fg[k] = '0;
      end
      @(posedge clk);
      #1;
      check_all(1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      int p0;
      int f0;
      do_reset();

      step(1'b1, 4'd9, 4'd3, 2'b00, 8'h00, 1'b0);
      idle();
      chk_eq("t1_cmp_vld", 8'(d_cmp), 8'h01);
      chk_eq("t1_pass_cnt", d_pc, 8'h01);

      step(1'b1, 4'd9, 4'd3, 2'b01, 8'h00, 1'b0);
      step(1'b1, 4'd8, 4'd1, 2'b10, 8'h00, 1'b0);
      step(1'b1, 4'd8, 4'd1, 2'b11, 8'h00, 1'b0);
      idle();
      idle();
      chk_eq("t2_pass_cnt", d_pc, 8'h04);
      chk_eq("t2_fail", 8'(d_fail), 8'h00);

      step(1'b1, 4'd9, 4'd3, 2'b01, 8'h01, 1'b0);
      idle();
      chk_eq("t3_err", 8'(d_err), 8'h01);
      chk_eq("t3_fail", 8'(d_fail), 8'h01);
      chk_eq("t3_ff_op", 8'(d_fo), 8'h01);
      chk_eq("t3_ff_exp", d_fe, 8'hF6);
      chk_eq("t3_ff_got", d_fg, 8'hF7);
      idle();
      chk_eq("t3_err_pulse", 8'(d_err), 8'h00);
      step(1'b1, 4'd2, 4'd2, 2'b00, 8'h10, 1'b0);
      idle();
      chk_eq("t3_fail_cnt", d_fc, 8'h02);
      chk_eq("t3_ff_exp_hold", d_fe, 8'hF6);
      chk_eq("t3_ff_got_hold", d_fg, 8'hF7);

      p0 = int'(d_pc);
      f0 = int'(d_fc);
      step(1'b1, 4'd1, 4'd1, 2'b00, 8'h00, 1'b0);
      step(1'b0, 4'd7, 4'd7, 2'b10, 8'h00, 1'b0);
      step(1'b1, 4'd2, 4'd3, 2'b01, 8'h00, 1'b0);
      idle();
      idle();
      chk_eq("t4_compares", 8'(int'(d_pc) - p0), 8'h02);
      chk_eq("t4_no_err", 8'(int'(d_fc) - f0), 8'h00);

      do_reset();
      for (int i = 0; i < 5; i++)
         step(1'b1, 4'(i), 4'd1, 2'b00, 8'h00, 1'b0);
      idle();
      idle();
      chk_eq("t5_sat_pass", 8'(s_pc), 8'h03);
      chk_eq("t5_wide_pass", d_pc, 8'h05);
      step(1'b1, 4'd1, 4'd1, 2'b00, 8'h04, 1'b0);
      step(1'b1, 4'd2, 4'd1, 2'b00, 8'h00, 1'b0);
      step(1'b0, 4'd0, 4'd0, 2'b00, 8'h00, 1'b1);
      chk_eq("t5_clr_fail_cnt", 8'(s_fc), 8'h01);
      chk_eq("t5_clr_fail", 8'(s_fail), 8'h01);
      idle();
      idle();

      for (int i = 0; i < 80; i++)
         step($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom),
              2'($urandom),
              ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
              $urandom_range(0, 15) == 0);
      idle();
      idle();

      step(1'b1, 4'd3, 4'd2, 2'b10, 8'h00, 1'b0);
      step(1'b1, 4'd5, 4'd6, 2'b01, 8'h00, 1'b0);
      rst = 1'b1;
      #1;
      chk_eq("t6_d_cmp_vld", 8'(d_cmp), 8'h00);
      chk_eq("t6_d_pass_cnt", d_pc, 8'h00);
      chk_eq("t6_s_pass_cnt", 8'(s_pc), 8'h00);
      chk_eq("t6_s_fail", 8'(s_fail), 8'h00);
      do_reset();
      for (int i = 0; i < 4; i++)
         idle();
      step(1'b1, 4'd4, 4'd4, 2'b11, 8'h00, 1'b0);
      idle();
      idle();
      chk_eq("t6_new_pass", 8'(s_pc), 8'h01);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
